// File: rtl/chip8_sprite_draw.sv
// chip8_sprite_draw
//   Executes the CHIP-8 DXYN draw. It reads N sprite bytes from sprite memory
//   starting at I and XORs each one into the 64x32 1bpp framebuffer. The
//   result is the VF collision flag. A row whose start column is not
//   byte-aligned touches two framebuffer bytes: the L byte, then the R byte.
//
// Parameters
//   CLIP_EDGES     1: pixels past the right or bottom edge are dropped
//                  0: pixels wrap mod 64 horizontally and mod 32 vertically
//
// Ports
//   clk_in, rst_in         clock and asynchronous active-low reset
//   start_in               one-cycle command strobe, sampled only in IDLE
//   x_in, y_in, n_in, i_in start column, start row, height in rows, sprite base address
//   busy_out, done_out     busy during the command; done is a one-cycle completion pulse
//   collision_out          VF result, held until the next accepted start
//   mem_addr_out           sprite byte address
//   mem_data_in            sprite byte (1-cycle read latency)
//   fb_addr_out            framebuffer byte address = row*8 + col/8
//   fb_rd_data_in          framebuffer read data (1-cycle read latency)
//   fb_wr_en_out           framebuffer write strobe
//   fb_wr_data_out         framebuffer write data
module chip8_sprite_draw #(
  parameter bit CLIP_EDGES = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [5:0]  x_in,
  input  logic [4:0]  y_in,
  input  logic [3:0]  n_in,
  input  logic [11:0] i_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        collision_out,
  output logic [11:0] mem_addr_out,
  input  logic [7:0]  mem_data_in,
  output logic [7:0]  fb_addr_out,
  input  logic [7:0]  fb_rd_data_in,
  output logic        fb_wr_en_out,
  output logic [7:0]  fb_wr_data_out
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_MEM_WAIT, S_RD_L, S_WAIT_L, S_WR_L,
    S_RD_R, S_WAIT_R, S_WR_R, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic [3:0]  n_q, n_d;
  logic [11:0] i_q, i_d;
  logic [3:0]  row_q, row_d;
  logic [15:0] sh_q, sh_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        coll_q, coll_d;
  logic [11:0] mem_addr_q, mem_addr_d;
  logic [7:0]  fb_addr_q, fb_addr_d;
  logic        fb_wr_en_q, fb_wr_en_d;
  logic [7:0]  fb_wr_data_q, fb_wr_data_d;

  logic [4:0]  ry;
  logic [4:0]  row_inc;
  logic [2:0]  col_r;
  logic        has_right;
  logic        last_row;
  logic        clipped;
  logic        advance;

  // The screen row truncates to 5 bits, which gives the vertical wrap.
  // With clipping, rows past the bottom edge are never reached.
  assign ry       = y_q + 5'(row_q);
  assign row_inc  = {1'b0, row_q} + 5'd1;
  assign col_r    = x_q[5:3] + 3'd1;
  assign last_row = (row_inc == {1'b0, n_q});
  assign clipped  = CLIP_EDGES && (({1'b0, y_q} + {1'b0, row_inc}) > 6'd31);
  // The R byte is needed only when the sprite straddles a byte boundary.
  // With clipping, an R byte past column 7 is dropped.
  assign has_right = (x_q[2:0] != 3'd0) && !(CLIP_EDGES && (x_q[5:3] == 3'd7));

  // Next-state and next-output logic. Outputs are registered. The XOR
  // result and collision are formed while the old framebuffer byte is on
  // fb_rd_data_in, and they appear during the write state.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    n_d          = n_q;
    i_d          = i_q;
    row_d        = row_q;
    sh_d         = sh_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    coll_d       = coll_q;
    mem_addr_d   = mem_addr_q;
    fb_addr_d    = fb_addr_q;
    fb_wr_en_d   = 1'b0;
    fb_wr_data_d = fb_wr_data_q;
    advance      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          x_d    = x_in;
          y_d    = y_in;
          n_d    = n_in;
          i_d    = i_in;
          row_d  = 4'd0;
          coll_d = 1'b0;
          if (n_in == 4'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d    = S_FETCH;
            busy_d     = 1'b1;
            mem_addr_d = i_in;
          end
        end
      end
      S_FETCH:    state_d = S_MEM_WAIT;
      S_MEM_WAIT: begin
        sh_d      = {mem_data_in, 8'h00} >> x_q[2:0];
        fb_addr_d = {ry, x_q[5:3]};
        state_d   = S_RD_L;
      end
      S_RD_L:     state_d = S_WAIT_L;
      S_WAIT_L: begin
        fb_wr_en_d   = 1'b1;
        fb_wr_data_d = fb_rd_data_in ^ sh_q[15:8];
        coll_d       = coll_q | (|(fb_rd_data_in & sh_q[15:8]));
        state_d      = S_WR_L;
      end
      S_WR_L: begin
        if (has_right) begin
          fb_addr_d = {ry, col_r};
          state_d   = S_RD_R;
        end else begin
          advance = 1'b1;
        end
      end
      S_RD_R:     state_d = S_WAIT_R;
      S_WAIT_R: begin
        fb_wr_en_d   = 1'b1;
        fb_wr_data_d = fb_rd_data_in ^ sh_q[7:0];
        coll_d       = coll_q | (|(fb_rd_data_in & sh_q[7:0]));
        state_d      = S_WR_R;
      end
      S_WR_R:     advance = 1'b1;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Row advance. With clipping, stop once the next row is past the bottom edge.
    if (advance) begin
      if (last_row || clipped) begin
        state_d = S_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else begin
        row_d      = row_inc[3:0];
        mem_addr_d = i_q + 12'(row_inc);
        state_d    = S_FETCH;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      n_q          <= '0;
      i_q          <= '0;
      row_q        <= '0;
      sh_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      coll_q       <= 1'b0;
      mem_addr_q   <= '0;
      fb_addr_q    <= '0;
      fb_wr_en_q   <= 1'b0;
      fb_wr_data_q <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      n_q          <= n_d;
      i_q          <= i_d;
      row_q        <= row_d;
      sh_q         <= sh_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      coll_q       <= coll_d;
      mem_addr_q   <= mem_addr_d;
      fb_addr_q    <= fb_addr_d;
      fb_wr_en_q   <= fb_wr_en_d;
      fb_wr_data_q <= fb_wr_data_d;
    end
  end

  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign collision_out  = coll_q;
  assign mem_addr_out   = mem_addr_q;
  assign fb_addr_out    = fb_addr_q;
  assign fb_wr_en_out   = fb_wr_en_q;
  assign fb_wr_data_out = fb_wr_data_q;

endmodule

// File: tb/tb_chip8_sprite_draw.sv
// tb_chip8_sprite_draw
//   Drives a clipping instance and a wrapping instance of chip8_sprite_draw
//   with the same commands. Each instance has its own framebuffer memory, and
//   the sprite memory is shared. A pixel-level reference model checks every
//   command.
module tb_chip8_sprite_draw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [5:0]  xIn;
  logic [4:0]  yIn;
  logic [3:0]  nIn;
  logic [11:0] iIn;

  logic        busyC, doneC, collC, wrEnC;
  logic [11:0] memAddrC;
  logic [7:0]  memRdC, fbAddrC, fbRdC, wrDataC;
  logic        busyW, doneW, collW, wrEnW;
  logic [11:0] memAddrW;
  logic [7:0]  memRdW, fbAddrW, fbRdW, wrDataW;

  chip8_sprite_draw #(.CLIP_EDGES(1'b1)) dutClip (
    .clk_in(clk), .rst_in(rst_n), .start_in(start),
    .x_in(xIn), .y_in(yIn), .n_in(nIn), .i_in(iIn),
    .busy_out(busyC), .done_out(doneC), .collision_out(collC),
    .mem_addr_out(memAddrC), .mem_data_in(memRdC),
    .fb_addr_out(fbAddrC), .fb_rd_data_in(fbRdC),
    .fb_wr_en_out(wrEnC), .fb_wr_data_out(wrDataC)
  );

  chip8_sprite_draw #(.CLIP_EDGES(1'b0)) dutWrap (
    .clk_in(clk), .rst_in(rst_n), .start_in(start),
    .x_in(xIn), .y_in(yIn), .n_in(nIn), .i_in(iIn),
    .busy_out(busyW), .done_out(doneW), .collision_out(collW),
    .mem_addr_out(memAddrW), .mem_data_in(memRdW),
    .fb_addr_out(fbAddrW), .fb_rd_data_in(fbRdW),
    .fb_wr_en_out(wrEnW), .fb_wr_data_out(wrDataW)
  );

  logic [7:0] mem  [4096];
  logic [7:0] fbC  [256];
  logic [7:0] fbW  [256];
  logic [7:0] mfbC [256];
  logic [7:0] mfbW [256];
  logic       clearFb;
  logic [7:0] clrIdx;
  int         wrCntC;
  int         wrCntW;

  // Synchronous-read memories with one cycle of latency. While clearFb is
  // high, one framebuffer byte is cleared per cycle.
  always @(posedge clk) begin
    memRdC <= mem[memAddrC];
    memRdW <= mem[memAddrW];
    fbRdC  <= fbC[fbAddrC];
    fbRdW  <= fbW[fbAddrW];
    if (clearFb) begin
      fbC[clrIdx] <= 8'h00;
      fbW[clrIdx] <= 8'h00;
    end else begin
      if (wrEnC) begin
        fbC[fbAddrC] <= wrDataC;
        wrCntC <= wrCntC + 1;
      end
      if (wrEnW) begin
        fbW[fbAddrW] <= wrDataW;
        wrCntW <= wrCntW + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  int resLatC, resLatW, resWrC, resWrW;
  bit resCollC, resCollW, heldCollC, heldCollW, busyBad;
  int mLatC, mLatW, mWrC, mWrW;
  bit mCollC, mCollW;

  typedef struct {
    bit          clr;
    bit          mid;
    logic [5:0]  x;
    logic [4:0]  y;
    logic [3:0]  n;
    logic [11:0] i;
    logic [7:0]  fill;
    int          expLat;
    int          expWr;
    bit          expColl;
    logic [7:0]  a0;
    logic [7:0]  v0;
    logic [7:0]  a1;
    logic [7:0]  v1;
  } vec_t;

  vec_t tv [5];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model. Sprite pixels are toggled one at a time on a 64x32
  // screen. Each row costs 5 cycles, plus 3 more when it spills into a
  // second byte that is kept.
  function automatic void modelDraw(input bit clip, input int x, input int y, input int n,
                                    input int i, output int lat, output int wr, output bit coll);
    lat = 1;
    wr = 0;
    coll = 1'b0;
    for (int r = 0; r < n; r++) begin
      int ry;
      logic [7:0] b;
      ry = y + r;
      if (clip && ry > 31) break;
      ry = ry % 32;
      b = mem[(i + r) % 4096];
      for (int p = 0; p < 8; p++) begin
        int col;
        int a;
        logic [7:0] m;
        if (b[7-p] == 1'b0) continue;
        col = x + p;
        if (clip && col > 63) continue;
        col = col % 64;
        a = ry * 8 + col / 8;
        m = 8'h80 >> (col % 8);
        if (clip) begin
          if ((mfbC[a] & m) != 8'h00) coll = 1'b1;
          mfbC[a] = mfbC[a] ^ m;
        end else begin
          if ((mfbW[a] & m) != 8'h00) coll = 1'b1;
          mfbW[a] = mfbW[a] ^ m;
        end
      end
      lat += 5;
      wr += 1;
      if ((x % 8) != 0 && !(clip && (x / 8) == 7)) begin
        lat += 3;
        wr += 1;
      end
    end
  endfunction

  task automatic clearAll();
    @(negedge clk);
    clearFb = 1'b1;
    for (int a = 0; a < 256; a++) begin
      clrIdx = 8'(a);
      mfbC[a] = 8'h00;
      mfbW[a] = 8'h00;
      @(negedge clk);
    end
    clearFb = 1'b0;
  endtask

  // Issues one command to both instances and records what they did. When
  // mid is set, a second start pulse with scrambled operands is sent while
  // the command is running.
  task automatic applyStimulus(input logic [5:0] x, input logic [4:0] y, input logic [3:0] n,
                               input logic [11:0] i, input bit mid);
    int snapC;
    int snapW;
    bit gotC;
    bit gotW;
    modelDraw(1'b1, int'(x), int'(y), int'(n), int'(i), mLatC, mWrC, mCollC);
    modelDraw(1'b0, int'(x), int'(y), int'(n), int'(i), mLatW, mWrW, mCollW);
    @(negedge clk);
    snapC = wrCntC;
    snapW = wrCntW;
    xIn = x; yIn = y; nIn = n; iIn = i;
    start = 1'b1;
    gotC = 1'b0; gotW = 1'b0; busyBad = 1'b0;
    resLatC = -1; resLatW = -1; resCollC = 1'b0; resCollW = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) start = 1'b0;
      if (mid && k == 3) begin
        start = 1'b1;
        xIn = ~x; yIn = ~y; nIn = ~n; iIn = ~i;
      end
      if (mid && k == 4) start = 1'b0;
      if (!gotC) begin
        if (doneC) begin
          gotC = 1'b1; resLatC = k; resCollC = collC;
          if (busyC) busyBad = 1'b1;
        end else if (!busyC) busyBad = 1'b1;
      end
      if (!gotW) begin
        if (doneW) begin
          gotW = 1'b1; resLatW = k; resCollW = collW;
          if (busyW) busyBad = 1'b1;
        end else if (!busyW) busyBad = 1'b1;
      end
      if (gotC && gotW) break;
    end
    @(posedge clk);
    #1;
    if (doneC || doneW || busyC || busyW) busyBad = 1'b1;
    heldCollC = collC;
    heldCollW = collW;
    resWrC = wrCntC - snapC;
    resWrW = wrCntW - snapW;
  endtask

  task automatic checkFb(input string name);
    int badC;
    int badW;
    badC = -1;
    badW = -1;
    for (int a = 0; a < 256; a++) begin
      if (badC < 0 && fbC[a] !== mfbC[a]) badC = a;
      if (badW < 0 && fbW[a] !== mfbW[a]) badW = a;
    end
    if (badC < 0) badC = 0;
    if (badW < 0) badW = 0;
    checkOutput({name, ".fbClip"}, int'(fbC[badC]), int'(mfbC[badC]));
    checkOutput({name, ".fbWrap"}, int'(fbW[badW]), int'(mfbW[badW]));
  endtask

  task automatic checkCommand(input string name);
    checkOutput({name, ".latClip"}, resLatC, mLatC);
    checkOutput({name, ".latWrap"}, resLatW, mLatW);
    checkOutput({name, ".collClip"}, int'(resCollC), int'(mCollC));
    checkOutput({name, ".collWrap"}, int'(resCollW), int'(mCollW));
    checkOutput({name, ".collHeldClip"}, int'(heldCollC), int'(mCollC));
    checkOutput({name, ".collHeldWrap"}, int'(heldCollW), int'(mCollW));
    checkOutput({name, ".writesClip"}, resWrC, mWrC);
    checkOutput({name, ".writesWrap"}, resWrW, mWrW);
    checkOutput({name, ".busyDone"}, int'(busyBad), 0);
    checkFb(name);
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, ".outsClip"},
                int'({busyC, doneC, collC, wrEnC, memAddrC, fbAddrC, wrDataC}), 0);
    checkOutput({name, ".outsWrap"},
                int'({busyW, doneW, collW, wrEnW, memAddrW, fbAddrW, wrDataW}), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    xIn = '0; yIn = '0; nIn = '0; iIn = '0;
    clearFb = 1'b0;
    clrIdx = '0;
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);

    tv[0] = '{clr:1'b1, mid:1'b0, x:6'd8,  y:5'd2,  n:4'd1, i:12'h200, fill:8'hFF,
              expLat:6,  expWr:1, expColl:1'b0, a0:8'h11, v0:8'hFF, a1:8'h10, v1:8'h00};
    tv[1] = '{clr:1'b0, mid:1'b0, x:6'd8,  y:5'd2,  n:4'd1, i:12'h200, fill:8'hFF,
              expLat:6,  expWr:1, expColl:1'b1, a0:8'h11, v0:8'h00, a1:8'h12, v1:8'h00};
    tv[2] = '{clr:1'b0, mid:1'b0, x:6'd5,  y:5'd9,  n:4'd0, i:12'h000, fill:8'h00,
              expLat:1,  expWr:0, expColl:1'b0, a0:8'h11, v0:8'h00, a1:8'h10, v1:8'h00};
    tv[3] = '{clr:1'b1, mid:1'b1, x:6'd3,  y:5'd0,  n:4'd1, i:12'h200, fill:8'hFF,
              expLat:9,  expWr:2, expColl:1'b0, a0:8'h00, v0:8'h1F, a1:8'h01, v1:8'hE0};
    tv[4] = '{clr:1'b1, mid:1'b0, x:6'd60, y:5'd30, n:4'd4, i:12'h300, fill:8'hFF,
              expLat:11, expWr:2, expColl:1'b0, a0:8'hF7, v0:8'h0F, a1:8'hFF, v1:8'h0F};

    clearAll();
    checkIdleOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int t = 0; t < 5; t++) begin
      if (tv[t].clr) clearAll();
      for (int r = 0; r < int'(tv[t].n); r++) mem[(int'(tv[t].i) + r) % 4096] = tv[t].fill;
      applyStimulus(tv[t].x, tv[t].y, tv[t].n, tv[t].i, tv[t].mid);
      checkCommand($sformatf("vec%0d", t));
      checkOutput($sformatf("vec%0d.specLat", t), resLatC, tv[t].expLat);
      checkOutput($sformatf("vec%0d.specWrites", t), resWrC, tv[t].expWr);
      checkOutput($sformatf("vec%0d.specColl", t), int'(resCollC), int'(tv[t].expColl));
      checkOutput($sformatf("vec%0d.specByteA", t), int'(fbC[tv[t].a0]), int'(tv[t].v0));
      checkOutput($sformatf("vec%0d.specByteB", t), int'(fbC[tv[t].a1]), int'(tv[t].v1));
    end

    // The wrapping instance on the corner sprite: both edges wrap.
    checkOutput("wrap.writes", resWrW, 8);
    checkOutput("wrap.lat", resLatW, 33);
    checkOutput("wrap.fbF0", int'(fbW[8'hF0]), 8'hF0);
    checkOutput("wrap.fbF8", int'(fbW[8'hF8]), 8'hF0);
    checkOutput("wrap.fb00", int'(fbW[8'h00]), 8'hF0);
    checkOutput("wrap.fb07", int'(fbW[8'h07]), 8'h0F);
    checkOutput("wrap.fb0F", int'(fbW[8'h0F]), 8'h0F);

    // Asynchronous reset during WAIT_L of row 2. Rows 0 and 1 stay written.
    clearAll();
    for (int r = 0; r < 4; r++) mem[12'h400 + r] = 8'($urandom_range(1, 255));
    begin
      int dl;
      int dw;
      bit dc;
      modelDraw(1'b1, 0, 0, 2, 12'h400, dl, dw, dc);
      modelDraw(1'b0, 0, 0, 2, 12'h400, dl, dw, dc);
    end
    @(negedge clk);
    xIn = 6'd0; yIn = 5'd0; nIn = 4'd4; iIn = 12'h400;
    start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) start = 1'b0;
    end
    checkOutput("midRst.busyBefore", int'(busyC & busyW), 1);
    #2 rst_n = 1'b0;
    #1 checkIdleOutputs("midRst");
    repeat (3) @(posedge clk);
    #1 checkIdleOutputs("midRstHeld");
    checkFb("midRst");
    @(negedge clk);
    rst_n = 1'b1;
    mem[12'h200] = 8'hFF;
    applyStimulus(6'd8, 5'd2, 4'd1, 12'h200, 1'b0);
    checkCommand("afterRst");

    // Random commands against the model. The framebuffer is kept between
    // commands so that collisions occur.
    clearAll();
    for (int t = 0; t < 40; t++) begin
      logic [3:0] rn;
      if (t == 20) clearAll();
      rn = 4'($urandom_range(0, 15));
      applyStimulus(6'($urandom), 5'($urandom), rn, 12'($urandom),
                    (rn != 4'd0) && ($urandom_range(0, 3) == 0));
      checkCommand($sformatf("rand%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
